// File: rtl/bram_fifo_ctrl_if.sv
// rtl/bram_fifo_ctrl_if.sv - request/status bundle between a FIFO user and bram_fifo_ctrl
// master = user side issuing writes/reads, slave = the controller driving bram and status.
interface bram_fifo_ctrl_if #(
    parameter int NB_ADDR_RAM = 10,
    parameter int NB_COUNT    = NB_ADDR_RAM + 1
);
    logic                   i_flush;
    logic                   i_write_valid;
    logic                   i_read_request;
    logic [NB_COUNT-1:0]    i_threshold;
    logic                   o_write_enable;
    logic [NB_ADDR_RAM-1:0] o_write_addr;
    logic                   o_read_enable;
    logic [NB_ADDR_RAM-1:0] o_read_addr;
    logic                   o_data_valid;
    logic [NB_COUNT-1:0]    o_count;
    logic                   o_full;
    logic                   o_empty;
    logic                   o_overflow;
    logic                   o_underflow;
    logic                   o_running;

    modport master (
        output i_flush, i_write_valid, i_read_request, i_threshold,
        input  o_write_enable, o_write_addr, o_read_enable, o_read_addr,
        input  o_data_valid, o_count, o_full, o_empty, o_overflow, o_underflow, o_running
    );

    modport slave (
        input  i_flush, i_write_valid, i_read_request, i_threshold,
        output o_write_enable, o_write_addr, o_read_enable, o_read_addr,
        output o_data_valid, o_count, o_full, o_empty, o_overflow, o_underflow, o_running
    );
endinterface

// File: rtl/bram_fifo_ctrl.sv
// rtl/bram_fifo_ctrl.sv - pointer/fill controller turning a dual-port bram into a thresholded circular FIFO
// Reads are held off in FILL until the fill threshold is met; an underflow in RUN re-primes the margin.
module bram_fifo_ctrl #(
    parameter int RAM_DEPTH   = 1024,
    parameter int NB_ADDR_RAM = $clog2(RAM_DEPTH),
    parameter int NB_COUNT    = NB_ADDR_RAM + 1
) (
    input  logic            i_clock,
    input  logic            i_rst_n,
    bram_fifo_ctrl_if.slave bus
);
    localparam logic [NB_COUNT-1:0]    DEPTH_C   = NB_COUNT'(RAM_DEPTH);
    localparam logic [NB_COUNT-1:0]    CNT_ONE   = NB_COUNT'(1);
    localparam logic [NB_ADDR_RAM-1:0] ADDR_LAST = NB_ADDR_RAM'(RAM_DEPTH - 1);
    localparam logic [NB_ADDR_RAM-1:0] ADDR_ONE  = NB_ADDR_RAM'(1);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state;
    logic [NB_ADDR_RAM-1:0] wr_ptr;
    logic [NB_ADDR_RAM-1:0] rd_ptr;
    logic [NB_COUNT-1:0]    count;
    logic [NB_COUNT-1:0]    thr_eff;
    logic                   full;
    logic                   empty;
    logic                   running;
    logic                   wr_en;
    logic                   rd_en;
    logic                   data_valid;
    logic                   overflow;
    logic                   underflow;

    // Enables are decided on pre-update state, so a full FIFO refuses a write even alongside a read.
    always_comb begin
        full    = (count == DEPTH_C);
        empty   = (count == '0);
        running = (state == RUN);
        thr_eff = (bus.i_threshold > DEPTH_C) ? DEPTH_C : bus.i_threshold;
        wr_en   = bus.i_write_valid & ~full & ~bus.i_flush;
        rd_en   = running & bus.i_read_request & ~empty & ~bus.i_flush;
    end

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= FILL;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (bus.i_flush) begin
            state      <= FILL;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= (wr_ptr == ADDR_LAST) ? '0 : wr_ptr + ADDR_ONE;
            if (rd_en) rd_ptr <= (rd_ptr == ADDR_LAST) ? '0 : rd_ptr + ADDR_ONE;

            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            data_valid <= rd_en;
            overflow   <= bus.i_write_valid & full;
            underflow  <= running & bus.i_read_request & empty;

            case (state)
                FILL:    if (count >= thr_eff) state <= RUN;
                RUN:     if (bus.i_read_request & empty) state <= FILL;
                default: state <= FILL;
            endcase
        end
    end

    assign bus.o_write_enable = wr_en;
    assign bus.o_write_addr   = wr_ptr;
    assign bus.o_read_enable  = rd_en;
    assign bus.o_read_addr    = rd_ptr;
    assign bus.o_data_valid   = data_valid;
    assign bus.o_count        = count;
    assign bus.o_full         = full;
    assign bus.o_empty        = empty;
    assign bus.o_overflow     = overflow;
    assign bus.o_underflow    = underflow;
    assign bus.o_running      = running;
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb/tb_bram_fifo_ctrl.sv - directed self-checking bench for bram_fifo_ctrl with an 8-word bram
module tb_bram_fifo_ctrl;
    localparam int DEPTH = 8;

    logic i_clock;
    logic i_rst_n;
    int   n_checks;
    int   n_pass;

    bram_fifo_ctrl_if #(.NB_ADDR_RAM(3), .NB_COUNT(4)) bus ();

    bram_fifo_ctrl #(.RAM_DEPTH(DEPTH)) dut (
        .i_clock (i_clock),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic set_in(input logic wv, input logic rr);
        bus.i_write_valid  = wv;
        bus.i_read_request = rr;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        i_rst_n            = 1'b0;
        bus.i_flush        = 1'b0;
        bus.i_write_valid  = 1'b0;
        bus.i_read_request = 1'b0;
        bus.i_threshold    = 4'd4;
        tick();
        tick();

        check("rst_count", bus.o_count, 0);
        check("rst_empty", bus.o_empty, 1);
        check("rst_full", bus.o_full, 0);
        check("rst_running", bus.o_running, 0);
        check("rst_we", bus.o_write_enable, 0);
        check("rst_re", bus.o_read_enable, 0);
        check("rst_waddr", bus.o_write_addr, 0);
        check("rst_raddr", bus.o_read_addr, 0);
        check("rst_dv", bus.o_data_valid, 0);
        check("rst_ovf", bus.o_overflow, 0);
        check("rst_unf", bus.o_underflow, 0);

        // threshold 4: fill four words, RUN one cycle after count reaches 4
        i_rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b0);
            check("fill_we", bus.o_write_enable, 1);
            check("fill_waddr", bus.o_write_addr, i);
            tick();
            check("fill_count", bus.o_count, i + 1);
            check("fill_running", bus.o_running, 0);
        end
        set_in(1'b0, 1'b0);
        tick();
        check("run_rise", bus.o_running, 1);
        check("run_dv_idle", bus.o_data_valid, 0);

        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b1);
            check("rd_re", bus.o_read_enable, 1);
            check("rd_raddr", bus.o_read_addr, i);
            tick();
            check("rd_dv", bus.o_data_valid, 1);
            check("rd_count", bus.o_count, 3 - i);
        end
        set_in(1'b0, 1'b0);
        tick();
        check("rd_dv_drop", bus.o_data_valid, 0);
        check("drained_empty", bus.o_empty, 1);
        check("drained_running", bus.o_running, 1);

        // read on empty while running: one underflow pulse, back to FILL
        set_in(1'b0, 1'b1);
        check("unf_re", bus.o_read_enable, 0);
        tick();
        check("unf_pulse", bus.o_underflow, 1);
        check("unf_to_fill", bus.o_running, 0);
        tick();
        check("unf_once", bus.o_underflow, 0);

        // refill with requests still held: FILL ignores them, write pointer wraps 7 -> 0
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b1);
            check("refill_re", bus.o_read_enable, 0);
            check("refill_waddr", bus.o_write_addr, 4 + i);
            tick();
            check("refill_unf", bus.o_underflow, 0);
        end
        check("wrap_waddr", bus.o_write_addr, 0);
        check("refill_count", bus.o_count, 4);
        set_in(1'b0, 1'b0);
        tick();
        check("rerun", bus.o_running, 1);

        set_in(1'b0, 1'b1);
        tick();
        check("pre_sim_count", bus.o_count, 3);

        // 20 simultaneous write+read cycles at count 3
        for (int k = 0; k < 20; k++) begin
            set_in(1'b1, 1'b1);
            check("sim_waddr", bus.o_write_addr, k % DEPTH);
            check("sim_raddr", bus.o_read_addr, (5 + k) % DEPTH);
            tick();
            check("sim_count", bus.o_count, 3);
        end
        check("sim_wptr_end", bus.o_write_addr, 4);
        check("sim_rptr_end", bus.o_read_addr, 1);

        set_in(1'b1, 1'b0);
        tick();
        tick();
        check("pre_flush_count", bus.o_count, 5);

        // flush mid-stream: enables killed, everything cleared next edge
        bus.i_flush = 1'b1;
        set_in(1'b1, 1'b1);
        check("flush_we", bus.o_write_enable, 0);
        check("flush_re", bus.o_read_enable, 0);
        tick();
        bus.i_flush = 1'b0;
        set_in(1'b0, 1'b0);
        check("flush_count", bus.o_count, 0);
        check("flush_waddr", bus.o_write_addr, 0);
        check("flush_raddr", bus.o_read_addr, 0);
        check("flush_running", bus.o_running, 0);
        check("flush_dv", bus.o_data_valid, 0);

        // threshold 8: nine writes, ninth dropped with one overflow pulse
        bus.i_threshold = 4'd8;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 1'b0);
            check("full_waddr", bus.o_write_addr, i);
            tick();
        end
        check("full_flag", bus.o_full, 1);
        check("full_count", bus.o_count, 8);
        check("full_wrap", bus.o_write_addr, 0);
        set_in(1'b1, 1'b0);
        check("ovf_we", bus.o_write_enable, 0);
        tick();
        check("ovf_pulse", bus.o_overflow, 1);
        check("ovf_count", bus.o_count, 8);
        check("ovf_running", bus.o_running, 1);
        set_in(1'b0, 1'b0);
        tick();
        check("ovf_once", bus.o_overflow, 0);

        // full with simultaneous read: write still refused
        set_in(1'b1, 1'b1);
        check("full_rw_we", bus.o_write_enable, 0);
        check("full_rw_re", bus.o_read_enable, 1);
        tick();
        check("full_rw_count", bus.o_count, 7);
        check("full_rw_ovf", bus.o_overflow, 1);
        set_in(1'b0, 1'b0);

        // threshold above depth saturates at 8
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        bus.i_threshold = 4'd15;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 1'b0);
            tick();
            check("clamp_hold", bus.o_running, 0);
        end
        set_in(1'b0, 1'b0);
        tick();
        check("clamp_run", bus.o_running, 1);

        // async reset mid-stream, then threshold 0 runs after the first edge
        set_in(1'b1, 1'b1);
        i_rst_n = 1'b0;
        #1;
        check("arst_count", bus.o_count, 0);
        check("arst_running", bus.o_running, 0);
        check("arst_raddr", bus.o_read_addr, 0);
        set_in(1'b0, 1'b0);
        bus.i_threshold = 4'd0;
        i_rst_n = 1'b1;
        #1;
        check("thr0_pre", bus.o_running, 0);
        tick();
        check("thr0_run", bus.o_running, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
